// File: rtl/codec_cfg_pkg.sv
// WM8731 bring-up configuration: FSM states, register addresses and the init table.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StWaitAck,
    StWaitFin,
    StGap
  } state_e;

  localparam int unsigned N_CMD = 9;

  // WM8731 register addresses (7-bit, upper bits of each 16-bit word)
  localparam logic [6:0] REG_LEFT_LINE_IN  = 7'h00;
  localparam logic [6:0] REG_RIGHT_LINE_IN = 7'h01;
  localparam logic [6:0] REG_LEFT_HP_OUT   = 7'h02;
  localparam logic [6:0] REG_RIGHT_HP_OUT  = 7'h03;
  localparam logic [6:0] REG_ANALOG_PATH   = 7'h04;
  localparam logic [6:0] REG_DIGITAL_PATH  = 7'h05;
  localparam logic [6:0] REG_POWER_DOWN    = 7'h06;
  localparam logic [6:0] REG_DIGITAL_IF    = 7'h07;
  localparam logic [6:0] REG_SAMPLING      = 7'h08;
  localparam logic [6:0] REG_ACTIVE        = 7'h09;
  localparam logic [6:0] REG_RESET         = 7'h0F;

  // Each word is {register address, 9-bit register data}; order matters (reset first,
  // activate last).
  localparam logic [15:0] INIT_TABLE [N_CMD] = '{
    {REG_RESET,         9'h000},
    {REG_POWER_DOWN,    9'h000},
    {REG_ANALOG_PATH,   9'h012},
    {REG_DIGITAL_PATH,  9'h000},
    {REG_DIGITAL_IF,    9'h042},
    {REG_SAMPLING,      9'h000},
    {REG_LEFT_LINE_IN,  9'h017},
    {REG_RIGHT_LINE_IN, 9'h017},
    {REG_ACTIVE,        9'h001}
  };

  // Table lookup; out-of-range indices read as zero.
  function automatic logic [15:0] init_word(input logic [3:0] idx);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < N_CMD; i++) begin
      if (idx == 4'(i)) w = INIT_TABLE[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/codec_init_sequencer.sv
// Walks the WM8731 init table and hands each word to the I2C sender as a 24-bit frame,
// with a settle gap between frames and a per-frame watchdog with bounded retries.
module codec_init_sequencer
  import codec_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR       = 8'h34,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRY      = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_finished,
  output logic        o_start,
  output logic [23:0] o_dat,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [3:0]  o_idx
);

  localparam int unsigned    WdW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WdW-1:0] WdLimit   = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [WdW-1:0] WdOne     = WdW'(1);
  localparam logic [15:0]    GapLoad   = 16'(GAP_CYCLES - 1);
  localparam logic [1:0]     RetryMax  = 2'(MAX_RETRY);
  localparam logic [3:0]     LastIdx   = 4'(N_CMD - 1);

  state_e         state_q;
  logic [15:0]    gap_q;
  logic [WdW-1:0] wd_q;
  logic [1:0]     retry_q;
  logic           resend_q;
  logic           launch_q;
  logic [3:0]     idx_q;
  logic [15:0]    cur_word;
  logic           wd_expired;

  assign cur_word   = init_word(idx_q);
  assign wd_expired = (wd_q == WdLimit);
  assign o_idx      = idx_q;

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      wd_q     <= '0;
      retry_q  <= '0;
      resend_q <= 1'b0;
      launch_q <= AUTO_START;
      idx_q    <= '0;
      o_start  <= 1'b0;
      o_dat    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      o_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start || launch_q) begin
            state_q  <= StWaitRdy;
            o_busy   <= 1'b1;
            o_done   <= 1'b0;
            o_error  <= 1'b0;
            idx_q    <= '0;
            retry_q  <= '0;
            resend_q <= 1'b0;
            launch_q <= 1'b0;
          end
        end
        StWaitRdy: begin
          if (i_finished) begin
            o_dat   <= {DEV_ADDR, cur_word};
            o_start <= 1'b1;
            wd_q    <= '0;
            state_q <= StWaitAck;
          end
        end
        StWaitAck, StWaitFin: begin
          if (wd_q != '1) wd_q <= wd_q + WdOne;
          // Progress from the sender wins over a coincident timeout.
          if (state_q == StWaitAck && !i_finished) begin
            state_q <= StWaitFin;
          end else if (state_q == StWaitFin && i_finished) begin
            gap_q   <= GapLoad;
            state_q <= StGap;
          end else if (wd_expired) begin
            if (retry_q < RetryMax) begin
              retry_q  <= retry_q + 2'd1;
              resend_q <= 1'b1;
              gap_q    <= GapLoad;
              state_q  <= StGap;
            end else begin
              o_error <= 1'b1;
              o_busy  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            if (resend_q) begin
              resend_q <= 1'b0;
              state_q  <= StWaitRdy;
            end else if (idx_q == LastIdx) begin
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              state_q <= StIdle;
            end else begin
              idx_q   <= idx_q + 4'd1;
              retry_q <= '0;
              state_q <= StWaitRdy;
            end
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Scoreboard bench for codec_init_sequencer: expected frames are queued by the stimulus,
// a monitor pops one per observed start pulse and checks data, index and timing.
module tb_codec_init_sequencer;

  typedef struct {
    logic [23:0] dat;
    logic [3:0]  idx;
    int          kind;  // 0 none, 1 gap after finish, 2 retry spacing, 3 reset latency
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fin = 1'b1;
  logic        o_start;
  logic [23:0] o_dat;
  logic        o_busy, o_done, o_error;
  logic [3:0]  o_idx;

  logic        start2 = 1'b0;
  logic        fin2 = 1'b1;
  logic        o_start2;
  logic [23:0] o_dat2;
  logic        o_busy2, o_done2, o_error2;
  logic [3:0]  o_idx2;

  logic [23:0] exp_words [9];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_starts = 0;
  int          n_starts2 = 0;
  bit          stall_en = 1'b0;
  int          sd_cnt = 0;

  codec_init_sequencer #(.AUTO_START(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_finished(fin),
    .o_start(o_start), .o_dat(o_dat), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_idx(o_idx)
  );

  codec_init_sequencer #(.AUTO_START(1'b0)) dut_manual (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_finished(fin2),
    .o_start(o_start2), .o_dat(o_dat2), .o_busy(o_busy2), .o_done(o_done2),
    .o_error(o_error2), .o_idx(o_idx2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not end, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int idx, input int kind);
    exp_t e;
    e.dat  = exp_words[idx];
    e.idx  = 4'(idx);
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic push_run(input int first_kind);
    push_frame(0, first_kind);
    for (int i = 1; i < 9; i++) push_frame(i, 1);
  endtask

  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_end(input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (o_done || o_error) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  // Behavioural sender: drops finished on start, raises it 75 cycles later.
  // In stall mode frame 3 is never acknowledged, so the sequencer's watchdog must fire.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fin    = 1'b1;
        sd_cnt = 0;
      end else begin
        #1;
        if (sd_cnt > 0) begin
          sd_cnt--;
          if (sd_cnt == 0) fin = 1'b1;
        end else if (o_start && !(stall_en && o_idx == 4'd3)) begin
          fin    = 1'b0;
          sd_cnt = 75;
        end
      end
    end
  end

  // Monitor: pops one expected frame per start pulse.
  initial begin
    int   since_fin, since_start, since_rst;
    logic fin_prev, start_prev;
    exp_t e;
    since_fin = 0; since_start = 0; since_rst = 0;
    fin_prev = 1'b1; start_prev = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) since_rst = 0; else since_rst++;
      if (fin && !fin_prev) since_fin = 0; else since_fin++;
      fin_prev = fin;
      since_start++;
      #1;
      if (start_prev) check("start_width", {31'd0, o_start}, 32'd0);
      start_prev = o_start;
      if (o_start) begin
        n_starts++;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_start: got start idx %0d dat 0x%h, expected no start",
                   o_idx, o_dat);
        end else begin
          e = sb.pop_front();
          check("frame_dat", {8'd0, o_dat}, {8'd0, e.dat});
          check("frame_idx", {28'd0, o_idx}, {28'd0, e.idx});
          case (e.kind)
            1: check("gap_after_fin", since_fin, 32'd17);
            2: check("retry_spacing", since_start, 32'd4113);
            3: check("reset_latency", since_rst, 32'd2);
            default: ;
          endcase
        end
        since_start = 0;
      end
    end
  end

  initial begin : manual_mon
    forever begin
      @(posedge clk);
      #1;
      if (o_start2) n_starts2++;
    end
  end

  task automatic check_idle_end(input string tag, input logic done, input logic err,
                                input logic [3:0] idx);
    check({tag, "_done"}, {31'd0, o_done}, {31'd0, done});
    check({tag, "_error"}, {31'd0, o_error}, {31'd0, err});
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_idx"}, {28'd0, o_idx}, {28'd0, idx});
  endtask

  initial begin
    int base;
    exp_words[0] = 24'h341E00; exp_words[1] = 24'h340C00; exp_words[2] = 24'h340812;
    exp_words[3] = 24'h340A00; exp_words[4] = 24'h340E42; exp_words[5] = 24'h341000;
    exp_words[6] = 24'h340017; exp_words[7] = 24'h340217; exp_words[8] = 24'h341201;

    // Reset state
    #3;
    check("rst_start", {31'd0, o_start}, 32'd0);
    check("rst_dat", {8'd0, o_dat}, 32'd0);
    check_idle_end("rst", 1'b0, 1'b0, 4'd0);

    // Auto-start run; a mid-sequence start request must be dropped
    push_run(3);
    base = n_starts;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    pulse(1'b0);
    wait_end(3000, "run1_end");
    check_idle_end("run1", 1'b1, 1'b0, 4'd8);
    repeat (50) @(posedge clk);
    check("run1_starts", n_starts - base, 32'd9);
    check("run1_drained", sb.size(), 32'd0);

    // Requested rerun after done
    push_run(0);
    base = n_starts;
    pulse(1'b0);
    check("rerun_done_drop", {31'd0, o_done}, 32'd0);
    check("rerun_busy", {31'd0, o_busy}, 32'd1);
    wait_end(3000, "rerun_end");
    check_idle_end("rerun", 1'b1, 1'b0, 4'd8);
    check("rerun_starts", n_starts - base, 32'd9);

    // Stalled sender on frame 3: initial send plus two retries, then error
    stall_en = 1'b1;
    for (int i = 0; i < 4; i++) push_frame(i, (i == 0) ? 0 : 1);
    push_frame(3, 2);
    push_frame(3, 2);
    base = n_starts;
    pulse(1'b0);
    wait_end(20000, "stall_end");
    check_idle_end("stall", 1'b0, 1'b1, 4'd3);
    repeat (5000) @(posedge clk);
    check("stall_starts", n_starts - base, 32'd6);
    check("stall_drained", sb.size(), 32'd0);
    stall_en = 1'b0;

    // Reset during frame 5, then auto restart from index 0
    push_run(0);
    pulse(1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (o_start && o_idx == 4'd5) break;
    end
    check("reach_frame5", {28'd0, o_idx}, 32'd5);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_start", {31'd0, o_start}, 32'd0);
    check("midrst_dat", {8'd0, o_dat}, 32'd0);
    check_idle_end("midrst", 1'b0, 1'b0, 4'd0);
    sb.delete();
    push_run(3);
    base = n_starts;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_end(3000, "restart_end");
    check_idle_end("restart", 1'b1, 1'b0, 4'd8);
    check("restart_starts", n_starts - base, 32'd9);

    // Manual-start instance: silent until requested
    check("manual_no_auto", n_starts2, 32'd0);
    check("manual_idle_busy", {31'd0, o_busy2}, 32'd0);
    pulse(1'b1);
    @(posedge clk);
    #1;
    check("manual_start", {31'd0, o_start2}, 32'd1);
    check("manual_dat", {8'd0, o_dat2}, 32'h00341E00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
